// File: rtl/spoc_mem_arbiter.sv
// Round-robin memory arbiter with a built-in word store.
// One transaction in flight: single read, single write or line burst.
module spoc_mem_arbiter #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int LINE_WORDS  = 8,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter int CWF         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req_valid,
  output logic [N_CH-1:0]            req_ready,
  input  logic [N_CH-1:0]            req_wr,
  input  logic [N_CH-1:0]            req_burst,
  input  logic [N_CH*ADDR_W-1:0]     req_addr,
  input  logic [N_CH*DATA_W-1:0]     req_wdata,
  input  logic [N_CH*DATA_W/8-1:0]   req_wstrb,
  output logic                       rsp_valid,
  output logic [$clog2(N_CH)-1:0]    rsp_ch,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_last,
  output logic                       rsp_wr,
  output logic                       busy
);

  localparam int CW    = $clog2(N_CH);
  localparam int SW    = DATA_W / 8;
  localparam int IW    = $clog2(DEPTH_WORDS);
  localparam int LW    = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     last_q;
  logic [CW-1:0]     ch_q;
  logic              wr_q;
  logic              burst_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     wstrb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LW-1:0]     beat_q;

  logic              rsp_valid_q;
  logic [CW-1:0]     rsp_ch_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;
  logic              rsp_wr_q;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [N_CH-1:0]   gnt_d;
  logic [CW-1:0]     gnt_idx_d;
  logic [CW-1:0]     cand;
  logic              found;
  logic [IW-1:0]     widx_d;
  logic [IW-1:0]     start_idx_d;
  logic [IW-1:0]     nxt_idx_d;

  always_comb begin
    gnt_d     = '0;
    gnt_idx_d = last_q;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CW'((int'(last_q) + k) % N_CH);
      if (!found && req_valid[cand]) begin
        gnt_d[cand] = 1'b1;
        gnt_idx_d   = cand;
        found       = 1'b1;
      end
    end
  end

  // Held in reset, IDLE must still not offer a grant.
  assign req_ready = (state_q == IDLE && rst) ? gnt_d : '0;

  assign widx_d = req_addr[gnt_idx_d*ADDR_W + 2 +: IW];

  always_comb begin
    start_idx_d = widx_d;
    if (CWF == 0 && !req_wr[gnt_idx_d] && req_burst[gnt_idx_d])
      start_idx_d = {widx_d[IW-1:LW], LW'(0)};
  end

  // Wrap inside the line; with CWF=0 the base start never wraps.
  assign nxt_idx_d = {idx_q[IW-1:LW], idx_q[LW-1:0] + LW'(1)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= CW'(N_CH - 1);
      ch_q        <= '0;
      wr_q        <= 1'b0;
      burst_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            last_q  <= gnt_idx_d;
            ch_q    <= gnt_idx_d;
            wr_q    <= req_wr[gnt_idx_d];
            burst_q <= req_burst[gnt_idx_d]
                       & ~req_wr[gnt_idx_d];
            idx_q   <= start_idx_d;
            wdata_q <= req_wdata[gnt_idx_d*DATA_W +: DATA_W];
            wstrb_q <= req_wstrb[gnt_idx_d*SW +: SW];
            cnt_q   <= CNT_W'(LATENCY);
            beat_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= BEAT;
            rsp_valid_q <= 1'b1;
            rsp_ch_q    <= ch_q;
            rsp_wr_q    <= wr_q;
            rsp_last_q  <= !burst_q;
            rsp_data_q  <= wr_q ? '0 : mem_q[idx_q];
            beat_q      <= beat_q + 1'b1;
            if (!wr_q)
              idx_q <= nxt_idx_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BEAT: begin
          if (rsp_last_q) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_data_q  <= '0;
          end else begin
            rsp_data_q <= mem_q[idx_q];
            rsp_last_q <= (beat_q == LW'(LINE_WORDS - 1));
            beat_q     <= beat_q + 1'b1;
            idx_q      <= nxt_idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Async reset clears state_q first, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == BEAT && wr_q) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb_q[b])
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_wr    = rsp_wr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/spoc_mem_arbiter.md
SPOC_MEM_ARBITER -- requirements
Module: spoc_mem_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requester channels (icache refill, icache uncache, dcache refill, dcache uncache).
REQ-002 Parameter DATA_W, default 32, word width; ADDR_W default 32, byte address width.
REQ-003 Parameter LINE_WORDS, default 8, burst length (power of two, >=2).
REQ-004 Parameter DEPTH_WORDS, default 4096, backing store size in words (power of two).
REQ-005 Parameter LATENCY, default 2, accept-to-first-response cycles (>=1).
REQ-006 Parameter CWF, default 0; 1 selects critical-word-first wrapping bursts.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 req_valid  input  N_CH  per-channel request valid.
REQ-010 req_ready  output  N_CH  per-channel accept, one-hot or zero.
REQ-011 req_wr  input  N_CH  1 = single-word write, 0 = read.
REQ-012 req_burst  input  N_CH  reads only: 1 = LINE_WORDS beats, 0 = single word.
REQ-013 req_addr  input  N_CH x ADDR_W  byte address per channel.
REQ-014 req_wdata  input  N_CH x DATA_W  write data; req_wstrb  input  N_CH x DATA_W/8  byte enables.
REQ-015 rsp_valid  output  1  response beat valid; no backpressure.
REQ-016 rsp_ch  output  clog2(N_CH)  channel owning the beat.
REQ-017 rsp_data  output  DATA_W  read data (0 on write acks); rsp_last  output  1  final beat; rsp_wr  output  1  beat is a write ack.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, WAIT, BEAT; one transaction outstanding at a time.
REQ-020 req_ready asserts only in IDLE, combinationally, for exactly the granted channel among asserted req_valid.
REQ-021 Round-robin: search starts at last_grant+1 mod N_CH; last_grant updates on each accept.
REQ-022 On accept edge: latch channel, wr, burst, addr, wdata, wstrb; load latency counter with LATENCY; go WAIT.
REQ-023 WAIT decrements counter each cycle; when counter reaches 1, go BEAT next edge, so first rsp_valid is high exactly LATENCY cycles after the accept edge.
REQ-024 Word index = addr[2 +: log2(DEPTH_WORDS)]; higher bits ignored (aliasing wrap); addr[1:0] ignored.
REQ-025 Burst, CWF=0: beats at line base (index with low log2(LINE_WORDS) bits cleared), then +1 per beat.
REQ-026 Burst, CWF=1: first beat at requested word, incrementing modulo LINE_WORDS within the same line.
REQ-027 Burst beats issue on consecutive cycles; rsp_last on the LINE_WORDS-th beat; then IDLE.
REQ-028 Single read: one beat, rsp_last=1, rsp_wr=0.
REQ-029 Write: bytes with wstrb set are written into the store on the edge ending the BEAT cycle; one ack beat with rsp_wr=1, rsp_last=1, rsp_data=0; wstrb=0 writes nothing but still acks.
REQ-030 req_burst ignored when req_wr=1.
REQ-031 Earliest next accept is the cycle after the rsp_last beat (IDLE); back-to-back transactions separated by exactly one IDLE cycle.
REQ-032 A later read to a written word returns the written data.
REQ-033 Channels not granted see req_ready=0 and must hold their request; the arbiter never drops a held request.

Reset
REQ-034 rst low immediately forces IDLE; req_ready, rsp_valid, rsp_last, rsp_wr, busy = 0; rsp_ch, rsp_data = 0; last_grant = N_CH-1.
REQ-035 Reset mid-transaction aborts it with no further beats; an aborted write does not modify the store.
REQ-036 Store contents are not reset; simulation initial contents are 0.

Verification
REQ-037 All four channels request reads at once after reset -> grants ch0,1,2,3 in order; each first beat LATENCY=2 cycles after its accept.
REQ-038 Ch2 writes 0xDEADBEEF to 0x40 with wstrb=4'b0011, prior content 0x11223344 -> single ack beat; subsequent single read of 0x40 returns 0x1122BEEF.
REQ-039 CWF=1, LINE_WORDS=8, burst read of 0x14 -> beats at word indices 5,6,7,0,1,2,3,4; rsp_last on the 8th beat; CWF=0 gives 0..7.
REQ-040 Read of 0x4000 with DEPTH_WORDS=4096 -> returns word 0 (alias).
REQ-041 rst asserted during beat 3 of a burst -> rsp_valid low same cycle; after release, ch0 wins the first grant.
REQ-042 Ch1 held continuously while ch0 issues repeated requests -> ch1 granted no later than the second arbitration.
